mem_port_arbiter: RTL

//  Shares the single memory access unit port between instruction fetch (port F, read-only)
//  and the control unit's load/store path (port D, read/write). Arbitrates, latches the

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory access unit between the instruction fetch port (F, read
// only) and the load/store port (D, read/write). A request is sampled only
// while idle; the winner's address, write data and operation are latched and
// a level enable is held towards the memory unit until it answers or the
// access times out. The owner then gets a one-cycle registered done pulse
// with err and read data.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   if_req / if_addr             F request and read address
//   if_done / if_err / if_rdata  F response (done is a 1-cycle pulse)
//   d_req / d_we / d_addr        D request, op (1=write) and address
//   d_wdata                      D write data
//   d_done / d_err / d_rdata     D response
//   memory_read_enable           level read enable to memory unit
//   memory_write_enable          level write enable to memory unit
//   memory_address               latched address
//   memory_write_data            latched write data
//   memory_read_data             read data from memory unit
//   memory_read_data_valid       read complete strobe
//   memory_write_done            write complete strobe
//   busy                         high while an access is in BUSY or RESP
//   grant_owner                  0=F, 1=D; owner of current/last access
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 255,
  parameter int DATA_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              memory_read_enable,
  output logic              memory_write_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_write_data,
  input  logic [DATA_W-1:0] memory_read_data,
  input  logic              memory_read_data_valid,
  input  logic              memory_write_done,
  output logic              busy,
  output logic              grant_owner
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_reg;
  logic [TW-1:0] timer_reg;
  logic          last_grant_reg;
  logic          op_we_reg;

  logic grant_valid;
  logic grant_d;
  logic completion;
  logic timed_out;
  logic finish_now;

  // Arbitration: a lone requester always wins; on a tie either D wins
  // outright or the port that did not win last time gets the turn.
  always_comb begin
    grant_valid = if_req | d_req;
    if (if_req && d_req) begin
      grant_d = (DATA_PRIORITY != 0) ? 1'b1 : ~last_grant_reg;
    end else begin
      grant_d = d_req;
    end
  end

  // Only the strobe matching the latched operation counts; the other kind is
  // ignored. Completion takes precedence over a simultaneous timeout.
  always_comb begin
    completion = op_we_reg ? memory_write_done : memory_read_data_valid;
    timed_out  = (timer_reg == TIMER_LAST);
    finish_now = (state_reg == S_BUSY) && (completion || timed_out);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= S_IDLE;
      timer_reg           <= '0;
      last_grant_reg      <= 1'b1;
      op_we_reg           <= 1'b0;
      grant_owner         <= 1'b0;
      busy                <= 1'b0;
      memory_read_enable  <= 1'b0;
      memory_write_enable <= 1'b0;
      memory_address      <= '0;
      memory_write_data   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            grant_owner         <= grant_d;
            last_grant_reg      <= grant_d;
            // F is always a read; D's op comes from d_we at grant time.
            op_we_reg           <= grant_d & d_we;
            memory_address      <= grant_d ? d_addr : if_addr;
            memory_write_data   <= grant_d ? d_wdata : '0;
            memory_read_enable  <= ~(grant_d & d_we);
            memory_write_enable <= grant_d & d_we;
            timer_reg           <= '0;
            busy                <= 1'b1;
            state_reg           <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (finish_now) begin
            memory_read_enable  <= 1'b0;
            memory_write_enable <= 1'b0;
            timer_reg           <= '0;
            state_reg           <= S_RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_RESP: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Per-port response registers: index 0 is F, index 1 is D. Only the owner
  // loads on the finishing BUSY cycle; every other cycle clears them, which
  // makes done a single-cycle pulse and keeps the non-owner at zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      localparam logic PORT_ID = (gi == 1);
      logic              done_reg;
      logic              err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else if (finish_now && (grant_owner == PORT_ID)) begin
          done_reg  <= 1'b1;
          err_reg   <= ~completion;
          rdata_reg <= (completion && !op_we_reg) ? memory_read_data : '0;
        end else begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end
      end
    end
  endgenerate

  assign if_done  = g_resp[0].done_reg;
  assign if_err   = g_resp[0].err_reg;
  assign if_rdata = g_resp[0].rdata_reg;
  assign d_done   = g_resp[1].done_reg;
  assign d_err    = g_resp[1].err_reg;
  assign d_rdata  = g_resp[1].rdata_reg;

endmodule
